// File: rtl/des_round_sequencer_if.sv
// Handshake and datapath-control bundle between the DES round sequencer and its environment.
// The master modport is the sequencer side; the slave modport is the requester/datapath side.
interface des_round_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             in_decrypt;
    logic             abort;
    logic             dp_load;
    logic             dp_round_en;
    logic [3:0]       round_idx;
    logic [1:0]       shift_amt;
    logic             shift_right;
    logic             dp_final;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] blk_count;

    modport master (
        input  in_valid, in_decrypt, abort, out_ready,
        output in_ready, dp_load, dp_round_en, round_idx, shift_amt, shift_right,
               dp_final, out_valid, busy, blk_count
    );

    modport slave (
        output in_valid, in_decrypt, abort, out_ready,
        input  in_ready, dp_load, dp_round_en, round_idx, shift_amt, shift_right,
               dp_final, out_valid, busy, blk_count
    );
endinterface

// File: rtl/des_round_sequencer.sv
// Control FSM for an iterative one-round-per-clock DES datapath: load, 16 rounds, final, hold.
// All outputs are registered, decoded from the next state so they line up with the state itself.
module des_round_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    des_round_sequencer_if.master bus
);
    localparam int unsigned RND_W = 4;
    localparam int unsigned AMT_W = 2;
    localparam logic [RND_W-1:0] LAST_ROUND = RND_W'(15);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        HOLD  = 3'd4
    } seqState_t;

    seqState_t        state;
    seqState_t        nextState;
    logic             modeQ;
    logic             modeD;
    logic [RND_W-1:0] roundQ;
    logic [RND_W-1:0] roundD;
    logic [CNT_W-1:0] blkCountQ;
    logic [CNT_W-1:0] blkCountD;
    logic [AMT_W-1:0] shiftAmtQ;
    logic [AMT_W-1:0] shiftAmtD;
    logic             shiftRightQ;
    logic             shiftRightD;
    logic             inReadyQ;
    logic             dpLoadQ;
    logic             dpRoundEnQ;
    logic             dpFinalQ;
    logic             outValidQ;
    logic             busyQ;

    // Key-schedule rotate amount; decryption skips the rotate on the first round.
    function automatic logic [AMT_W-1:0] shiftFor(input logic [RND_W-1:0] idx, input logic dec);
        logic single;
        single = (idx == RND_W'(0)) || (idx == RND_W'(1)) || (idx == RND_W'(8)) || (idx == RND_W'(15));
        if (dec && (idx == RND_W'(0))) begin
            return AMT_W'(0);
        end else if (single) begin
            return AMT_W'(1);
        end
        return AMT_W'(2);
    endfunction

    // Next-state, mode latch, round counter and completion counter.
    always_comb begin
        nextState = state;
        modeD     = modeQ;
        roundD    = RND_W'(0);
        blkCountD = blkCountQ;
        unique case (state)
            IDLE: begin
                if (!bus.abort && bus.in_valid) begin
                    nextState = LOAD;
                    modeD     = bus.in_decrypt;
                end
            end
            LOAD: begin
                nextState = bus.abort ? IDLE : ROUND;
            end
            ROUND: begin
                if (bus.abort) begin
                    nextState = IDLE;
                end else if (roundQ == LAST_ROUND) begin
                    nextState = FINAL;
                end else begin
                    roundD = roundQ + RND_W'(1);
                end
            end
            FINAL: begin
                nextState = bus.abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    nextState = IDLE;
                    if (blkCountQ != {CNT_W{1'b1}}) begin
                        blkCountD = blkCountQ + CNT_W'(1);
                    end
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Shift schedule is only meaningful while a round executes.
    always_comb begin
        shiftAmtD   = AMT_W'(0);
        shiftRightD = 1'b0;
        if (nextState == ROUND) begin
            shiftAmtD   = shiftFor(roundD, modeD);
            shiftRightD = modeD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            modeQ       <= 1'b0;
            roundQ      <= RND_W'(0);
            blkCountQ   <= CNT_W'(0);
            shiftAmtQ   <= AMT_W'(0);
            shiftRightQ <= 1'b0;
            inReadyQ    <= 1'b1;
            dpLoadQ     <= 1'b0;
            dpRoundEnQ  <= 1'b0;
            dpFinalQ    <= 1'b0;
            outValidQ   <= 1'b0;
            busyQ       <= 1'b0;
        end else begin
            state       <= nextState;
            modeQ       <= modeD;
            roundQ      <= roundD;
            blkCountQ   <= blkCountD;
            shiftAmtQ   <= shiftAmtD;
            shiftRightQ <= shiftRightD;
            inReadyQ    <= (nextState == IDLE);
            dpLoadQ     <= (nextState == LOAD);
            dpRoundEnQ  <= (nextState == ROUND);
            dpFinalQ    <= (nextState == FINAL);
            outValidQ   <= (nextState == HOLD);
            busyQ       <= (nextState != IDLE);
        end
    end

    assign bus.in_ready    = inReadyQ;
    assign bus.dp_load     = dpLoadQ;
    assign bus.dp_round_en = dpRoundEnQ;
    assign bus.round_idx   = roundQ;
    assign bus.shift_amt   = shiftAmtQ;
    assign bus.shift_right = shiftRightQ;
    assign bus.dp_final    = dpFinalQ;
    assign bus.out_valid   = outValidQ;
    assign bus.busy        = busyQ;
    assign bus.blk_count   = blkCountQ;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Self-checking bench for des_round_sequencer: directed and randomized blocks checked
// against a timeline model of the block (accept, load, 16 rounds, final, hold).
module tb_des_round_sequencer;
    localparam int unsigned CNT_W = 2;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_round_sequencer_if #(.CNT_W(CNT_W)) bus ();
    des_round_sequencer #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int edgeCnt = 0;
    int modelCount = 0;
    int encTab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int decTab [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always @(posedge clk) edgeCnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input bit rdy, input bit ld, input bit ren,
                            input int idx, input int amt, input bit rt, input bit fin,
                            input bit ov, input bit bsy);
        check({tag, ".in_ready"},    32'(bus.in_ready),    32'(rdy));
        check({tag, ".dp_load"},     32'(bus.dp_load),     32'(ld));
        check({tag, ".dp_round_en"}, 32'(bus.dp_round_en), 32'(ren));
        check({tag, ".round_idx"},   32'(bus.round_idx),   32'(idx));
        check({tag, ".shift_amt"},   32'(bus.shift_amt),   32'(amt));
        check({tag, ".shift_right"}, 32'(bus.shift_right), 32'(rt));
        check({tag, ".dp_final"},    32'(bus.dp_final),    32'(fin));
        check({tag, ".out_valid"},   32'(bus.out_valid),   32'(ov));
        check({tag, ".busy"},        32'(bus.busy),        32'(bsy));
        check({tag, ".blk_count"},   32'(bus.blk_count),   32'(modelCount));
    endtask

    task automatic expectIdle(input string tag);
        checkAll(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Cycle c after the accepting edge: 0 = load, 1..16 = round c-1, 17 = final.
    task automatic expectPhase(input int c, input bit dec);
        if (c == 0) begin
            checkAll("load", 0, 1, 0, 0, 0, 0, 0, 0, 1);
        end else if (c <= 16) begin
            checkAll($sformatf("round%0d", c - 1), 0, 0, 1, c - 1,
                     dec ? decTab[c-1] : encTab[c-1], dec, 0, 0, 1);
        end else begin
            checkAll("final", 0, 0, 0, 0, 0, 0, 1, 0, 1);
        end
    endtask

    // One block; abortAt/rstAt name the phase cycle at which to abort or reset (-1 = never).
    task automatic runBlock(input bit dec, input int hold, input int abortAt, input int rstAt);
        @(negedge clk);
        expectIdle("idle");
        bus.in_valid   = 1'b1;
        bus.in_decrypt = dec;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'($urandom_range(0, 1));
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            expectPhase(c, dec);
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_decrypt = 1'($urandom_range(0, 1));
            bus.out_ready  = 1'($urandom_range(0, 1));
            bus.abort      = (c == abortAt);
            if (c == rstAt) begin
                rst_n = 1'b0;
                modelCount = 0;
                #1;
                expectIdle("asyncReset");
                bus.in_valid  = 1'b0;
                bus.abort     = 1'b0;
                bus.out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (c == abortAt) begin
                @(negedge clk);
                expectIdle("afterAbort");
                bus.in_valid = 1'b0;
                bus.abort    = 1'b0;
                return;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            checkAll("hold", 0, 0, 0, 0, 0, 0, 0, 1, 1);
            bus.abort      = 1'($urandom_range(0, 1));
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.in_decrypt = 1'($urandom_range(0, 1));
            bus.out_ready  = (h == hold);
        end
        @(negedge clk);
        if (modelCount < MAXC) modelCount++;
        expectIdle("afterHandshake");
        bus.in_valid  = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int acceptEdge;
        int prevAccept;
        bus.in_valid   = 1'b0;
        bus.in_decrypt = 1'b0;
        bus.abort      = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        expectIdle("reset");
        rst_n = 1'b1;

        runBlock(1'b0, 0, -1, -1);                   // encrypt
        runBlock(1'b1, 0, -1, -1);                   // decrypt
        runBlock(1'($urandom_range(0, 1)), 10, -1, -1); // backpressure
        runBlock(1'b0, 0, 8, -1);                    // abort at round_idx 7
        runBlock(1'b0, 0, -1, -1);

        // abort has priority over in_valid while idle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        @(negedge clk);
        expectIdle("idleAbort");
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;

        runBlock(1'b1, 0, -1, 6);                    // reset at round_idx 5
        runBlock(1'b0, 0, -1, -1);

        for (int b = 0; b < 14; b++) begin
            runBlock(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : -1, -1);
        end

        // clear the counter, then back-to-back blocks to reach saturation
        @(negedge clk);
        rst_n = 1'b0;
        modelCount = 0;
        #1;
        expectIdle("resetBeforeSat");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        bus.in_decrypt = 1'($urandom_range(0, 1));
        prevAccept = 0;
        for (int b = 0; b < 5; b++) begin
            w = 0;
            while (bus.in_ready !== 1'b1 && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("satReadyWait", 32'(w < 40), 32'(1));
            acceptEdge = edgeCnt + 1;
            // 19 edges separate consecutive accepts
            if (b > 0) check("acceptGap", 32'(acceptEdge - prevAccept - 1), 32'(19));
            prevAccept = acceptEdge;
            @(negedge clk);
            w = 0;
            while (bus.out_valid !== 1'b1 && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("outValidLatency", 32'(edgeCnt - acceptEdge), 32'(18));
            @(negedge clk);
            if (modelCount < MAXC) modelCount++;
            check("satCount", 32'(bus.blk_count), 32'(modelCount));
            check("satReady", 32'(bus.in_ready), 32'(1));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
